i2c_eeprom_slave: RTL and testbench

//  Byte-addressed I2C target (EEPROM model) directly downstream of I2C_Master.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/i2c_line_sync.sv | 64 ++++++
 rtl/i2c_eeprom_slave.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and ACK/NACK bus levels,
// common to the EEPROM target and the I2C master.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEVA,
        ACK_D,
        REGA,
        ACK_R,
        WDATA,
        ACK_W,
        RDATA,
        MACK,
        WAITP
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Pointer advance with wrap at the array depth (mask = depth - 1).
    function automatic logic [7:0] ptr_inc(input logic [7:0] ptr, input logic [7:0] mask);
        return (ptr + 8'd1) & mask;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchroniser with START/STOP and SCL edge pulse generation.
// Pulses and the sampled SDA level are registered, so events appear 3 cycles after the pins move.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic [SYNC_STAGES-1:0] scl_sync_reg;
    logic [SYNC_STAGES-1:0] sda_sync_reg;
    logic                   scl_hist_reg;
    logic                   sda_hist_reg;
    logic                   scl_rise_reg;
    logic                   scl_fall_reg;
    logic                   start_reg;
    logic                   stop_reg;
    logic                   sda_bit_reg;
    logic                   scl_now;
    logic                   sda_now;

    assign scl_now = scl_sync_reg[SYNC_STAGES-1];
    assign sda_now = sda_sync_reg[SYNC_STAGES-1];

    // START/STOP need SCL stable high across the SDA transition, so they never
    // coincide with an SCL edge in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_reg <= {SYNC_STAGES{1'b1}};
            sda_sync_reg <= {SYNC_STAGES{1'b1}};
            scl_hist_reg <= 1'b1;
            sda_hist_reg <= 1'b1;
            scl_rise_reg <= 1'b0;
            scl_fall_reg <= 1'b0;
            start_reg    <= 1'b0;
            stop_reg     <= 1'b0;
            sda_bit_reg  <= 1'b1;
        end else begin
            scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_in};
            sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
            scl_hist_reg <= scl_now;
            sda_hist_reg <= sda_now;
            scl_rise_reg <= scl_now & ~scl_hist_reg;
            scl_fall_reg <= ~scl_now & scl_hist_reg;
            start_reg    <= scl_now & scl_hist_reg & ~sda_now & sda_hist_reg;
            stop_reg     <= scl_now & scl_hist_reg & sda_now & ~sda_hist_reg;
            sda_bit_reg  <= sda_now;
        end
    end

    assign scl_rise  = scl_rise_reg;
    assign scl_fall  = scl_fall_reg;
    assign start_det = start_reg;
    assign stop_det  = stop_reg;
    assign sda_bit   = sda_bit_reg;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// Byte-addressed I2C EEPROM target: write, random read and sequential read
// over an oversampled bus, with a persistent auto-incrementing byte pointer.
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         MEM_DEPTH   = 256,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    localparam int         ADDR_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [7:0] PTR_MASK = 8'(MEM_DEPTH - 1);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_bit;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_line_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .sda_bit  (sda_bit)
    );

    i2c_state_t state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] ptr_reg, ptr_next;
    logic       rw_reg, rw_next;
    logic       mack_reg, mack_next;
    logic       sda_out_reg, sda_out_next;
    logic       busy_reg, busy_next;
    logic       wr_strobe_reg, wr_strobe_next;
    logic [7:0] wr_addr_reg, wr_addr_next;
    logic [7:0] wr_data_reg, wr_data_next;
    logic       mem_we;
    logic [7:0] rd_data_reg;
    logic [7:0] mem [MEM_DEPTH];

    // rd_data_reg tracks mem[ptr] continuously; ptr is always settled long
    // before the SCL fall that loads a read byte into the shifter.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_reg[ADDR_W-1:0]] <= shift_reg;
        end
        rd_data_reg <= mem[ptr_reg[ADDR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 4'd0;
            shift_reg     <= 8'd0;
            ptr_reg       <= 8'd0;
            rw_reg        <= 1'b0;
            mack_reg      <= I2C_NACK;
            sda_out_reg   <= 1'b1;
            busy_reg      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 8'd0;
            wr_data_reg   <= 8'd0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            ptr_reg       <= ptr_next;
            rw_reg        <= rw_next;
            mack_reg      <= mack_next;
            sda_out_reg   <= sda_out_next;
            busy_reg      <= busy_next;
            wr_strobe_reg <= wr_strobe_next;
            wr_addr_reg   <= wr_addr_next;
            wr_data_reg   <= wr_data_next;
        end
    end

    // Receive/ACK states count SCL rises; RDATA counts the falls it has driven.
    always_comb begin
        state_next = state_reg;
        if (stop_det) begin
            state_next = IDLE;
        end else if (start_det) begin
            state_next = DEVA;
        end else if (scl_fall) begin
            case (state_reg)
                DEVA:  if (bit_cnt_reg == 4'd8) state_next = (shift_reg[7:1] == DEV_ADDR) ? ACK_D : WAITP;
                ACK_D: if (bit_cnt_reg == 4'd1) state_next = rw_reg ? RDATA : REGA;
                REGA:  if (bit_cnt_reg == 4'd8) state_next = ACK_R;
                ACK_R: if (bit_cnt_reg == 4'd1) state_next = WDATA;
                WDATA: if (bit_cnt_reg == 4'd8) state_next = ACK_W;
                ACK_W: if (bit_cnt_reg == 4'd1) state_next = WDATA;
                RDATA: if (bit_cnt_reg == 4'd7) state_next = MACK;
                MACK:  if (bit_cnt_reg == 4'd1) state_next = (mack_reg == I2C_ACK) ? RDATA : WAITP;
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        ptr_next       = ptr_reg;
        rw_next        = rw_reg;
        mack_next      = mack_reg;
        sda_out_next   = sda_out_reg;
        busy_next      = busy_reg;
        wr_strobe_next = 1'b0;
        wr_addr_next   = wr_addr_reg;
        wr_data_next   = wr_data_reg;
        mem_we         = 1'b0;
        if (stop_det) begin
            sda_out_next = 1'b1;
            busy_next    = 1'b0;
            bit_cnt_next = 4'd0;
        end else if (start_det) begin
            sda_out_next = 1'b1;
            busy_next    = 1'b1;
            bit_cnt_next = 4'd0;
        end else if (scl_rise) begin
            case (state_reg)
                DEVA, REGA, WDATA: begin
                    shift_next   = {shift_reg[6:0], sda_bit};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
                ACK_D, ACK_R, ACK_W: bit_cnt_next = bit_cnt_reg + 4'd1;
                MACK: begin
                    mack_next    = sda_bit;
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_reg)
                DEVA: if (bit_cnt_reg == 4'd8) begin
                    bit_cnt_next = 4'd0;
                    rw_next      = shift_reg[0];
                    sda_out_next = (shift_reg[7:1] == DEV_ADDR) ? I2C_ACK : I2C_NACK;
                end
                ACK_D: if (bit_cnt_reg == 4'd1) begin
                    bit_cnt_next = 4'd0;
                    if (rw_reg) begin
                        shift_next   = rd_data_reg;
                        sda_out_next = rd_data_reg[7];
                    end else begin
                        sda_out_next = 1'b1;
                    end
                end
                REGA: if (bit_cnt_reg == 4'd8) begin
                    bit_cnt_next = 4'd0;
                    ptr_next     = shift_reg & PTR_MASK;
                    sda_out_next = I2C_ACK;
                end
                WDATA: if (bit_cnt_reg == 4'd8) begin
                    bit_cnt_next   = 4'd0;
                    mem_we         = 1'b1;
                    wr_strobe_next = 1'b1;
                    wr_addr_next   = ptr_reg;
                    wr_data_next   = shift_reg;
                    ptr_next       = ptr_inc(ptr_reg, PTR_MASK);
                    sda_out_next   = I2C_ACK;
                end
                ACK_R, ACK_W: if (bit_cnt_reg == 4'd1) begin
                    bit_cnt_next = 4'd0;
                    sda_out_next = 1'b1;
                end
                RDATA: begin
                    if (bit_cnt_reg == 4'd7) begin
                        bit_cnt_next = 4'd0;
                        sda_out_next = 1'b1;
                        ptr_next     = ptr_inc(ptr_reg, PTR_MASK);
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        sda_out_next = shift_reg[6];
                        shift_next   = {shift_reg[6:0], 1'b0};
                    end
                end
                MACK: if (bit_cnt_reg == 4'd1) begin
                    bit_cnt_next = 4'd0;
                    if (mack_reg == I2C_ACK) begin
                        shift_next   = rd_data_reg;
                        sda_out_next = rd_data_reg[7];
                    end else begin
                        sda_out_next = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_out   = sda_out_reg;
    assign busy      = busy_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed bench for i2c_eeprom_slave: bit-banged I2C master plus a
// transaction-level EEPROM model (memory array, pointer, expected write queue).
module tb_i2c_eeprom_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic       sda_out;
    logic       busy;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    always #5 clk = ~clk;

    i2c_eeprom_slave dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .sda_out  (sda_out),
        .busy     (busy),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0]  m_mem [256];
    logic [7:0]  m_ptr = 8'd0;
    logic        m_busy = 1'b0;
    logic        m_match = 1'b0;
    bit          m_dev_pending = 1'b0;
    bit          m_reg_phase = 1'b0;
    logic [15:0] exp_q [$];
    int          strobe_cnt = 0;
    logic [7:0]  last_addr = 8'd0;
    logic [7:0]  last_data = 8'd0;
    bit          settled = 1'b0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of write strobes and the busy flag against the model.
    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (wr_strobe) begin
                    strobe_cnt++;
                    last_addr = wr_addr;
                    last_data = wr_data;
                    if (exp_q.size() == 0) begin
                        chk("unexpected wr_strobe", 16'(wr_addr), 16'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 16'(wr_addr), 16'(e[15:8]));
                        chk("wr_data", 16'(wr_data), 16'(e[7:0]));
                    end
                end
                if (settled) chk("busy", 16'(busy), 16'(m_busy));
            end
        end
    endtask

    // Every drive starts and ends at a posedge; lines change on a negedge.
    task automatic drive(input logic s, input logic d);
        settled = 1'b0;
        @(negedge clk);
        scl_in = s;
        sda_in = d;
        repeat (6) @(posedge clk);
        settled = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic sample(output logic v);
        @(negedge clk);
        v = sda_out;
        @(posedge clk);
    endtask

    task automatic i2c_start();
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        m_busy = 1'b1;
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        m_dev_pending = 1'b1;
    endtask

    task automatic i2c_stop();
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        m_busy = 1'b0;
        drive(1'b1, 1'b1);
        m_match = 1'b0;
        m_dev_pending = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, b[7-i]);
            drive(1'b1, b[7-i]);
            drive(1'b0, b[7-i]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input string name);
        logic exp_ack;
        logic v;
        if (m_dev_pending) begin
            m_dev_pending = 1'b0;
            m_match       = (b[7:1] == 7'h50);
            m_reg_phase   = 1'b1;
            exp_ack       = m_match ? 1'b0 : 1'b1;
        end else if (!m_match) begin
            exp_ack = 1'b1;
        end else if (m_reg_phase) begin
            m_reg_phase = 1'b0;
            m_ptr       = b;
            exp_ack     = 1'b0;
        end else begin
            exp_q.push_back({m_ptr, b});
            m_mem[m_ptr] = b;
            m_ptr        = m_ptr + 8'd1;
            exp_ack      = 1'b0;
        end
        send_bits(b, 8);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        sample(v);
        chk({"ack ", name}, 16'(v), 16'(exp_ack));
        drive(1'b0, 1'b1);
        $display("TXN send %s byte=%h ack_bit=%b", name, b, v);
    endtask

    task automatic recv_byte(input logic ack, input string name, output logic [7:0] got);
        logic v;
        logic [7:0] exp_b;
        exp_b = m_mem[m_ptr];
        m_ptr = m_ptr + 8'd1;
        for (int i = 7; i >= 0; i--) begin
            drive(1'b0, 1'b1);
            drive(1'b1, 1'b1);
            sample(v);
            got[i] = v;
            drive(1'b0, 1'b1);
        end
        chk({"read ", name}, 16'(got), 16'(exp_b));
        drive(1'b0, ack);
        drive(1'b1, ack);
        sample(v);
        chk({"sda released in master-ack slot ", name}, 16'(v), 16'h0001);
        drive(1'b0, ack);
        $display("TXN recv %s byte=%h master_ack=%b", name, got, ack);
    endtask

    task automatic write_txn(input logic [7:0] reg_a, input logic [7:0] d0, input logic [7:0] d1, input int n);
        i2c_start();
        send_byte(8'hA0, "dev+W");
        send_byte(reg_a, "reg");
        send_byte(d0, "data0");
        if (n > 1) send_byte(d1, "data1");
        i2c_stop();
    endtask

    initial begin
        logic [7:0] got;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset sda_out", 16'(sda_out), 16'h0001);
        chk("reset busy", 16'(busy), 16'h0000);
        chk("reset wr_strobe", 16'(wr_strobe), 16'h0000);
        chk("reset wr_addr", 16'(wr_addr), 16'h0000);
        chk("reset wr_data", 16'(wr_data), 16'h0000);
        rst = 1'b1;
        repeat (4) @(posedge clk);

        // 1: reset in the middle of the device address
        i2c_start();
        m_dev_pending = 1'b0;
        send_bits(8'hA0, 3);
        settled = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_busy = 1'b0;
        m_match = 1'b0;
        m_ptr = 8'd0;
        @(negedge clk);
        chk("mid-DEVA reset sda_out", 16'(sda_out), 16'h0001);
        chk("mid-DEVA reset busy", 16'(busy), 16'h0000);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        write_txn(8'h12, 8'h77, 8'h00, 1);

        // 2: two-byte write at 0x10
        write_txn(8'h10, 8'hA5, 8'h3C, 2);
        chk("strobe count after write", 16'(strobe_cnt), 16'd3);
        chk("last wr_addr", 16'(last_addr), 16'h0011);
        chk("last wr_data", 16'(last_data), 16'h003C);

        // 3: random read of two bytes, then a current-address read
        i2c_start();
        send_byte(8'hA0, "dev+W");
        send_byte(8'h10, "reg");
        i2c_start();
        send_byte(8'hA1, "dev+R");
        recv_byte(1'b0, "rd0", got);
        chk("literal rd0", 16'(got), 16'h00A5);
        recv_byte(1'b1, "rd1", got);
        chk("literal rd1", 16'(got), 16'h003C);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, "dev+R current");
        recv_byte(1'b1, "rd current", got);
        chk("literal current-address read", 16'(got), 16'h0077);
        i2c_stop();

        // 4: wrong device address
        i2c_start();
        send_byte(8'hA2, "dev 0x51+W");
        send_byte(8'h05, "reg to other dev");
        i2c_stop();
        chk("strobe count after foreign write", 16'(strobe_cnt), 16'd3);

        // 5: pointer wrap on write and read
        write_txn(8'hFF, 8'h11, 8'h22, 2);
        i2c_start();
        send_byte(8'hA0, "dev+W");
        send_byte(8'hFF, "reg");
        i2c_start();
        send_byte(8'hA1, "dev+R");
        recv_byte(1'b0, "wrap rd0", got);
        chk("literal wrap rd0", 16'(got), 16'h0011);
        recv_byte(1'b1, "wrap rd1", got);
        chk("literal wrap rd1", 16'(got), 16'h0022);
        i2c_stop();

        // 6: STOP four bits into a data byte
        i2c_start();
        send_byte(8'hA0, "dev+W");
        send_byte(8'h40, "reg");
        send_byte(8'h5A, "data0");
        send_bits(8'h99, 4);
        i2c_stop();
        chk("strobe count after abandoned byte", 16'(strobe_cnt), 16'd6);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("busy after abandoned byte", 16'(busy), 16'h0000);
        @(posedge clk);
        i2c_start();
        send_byte(8'hA0, "dev+W");
        send_byte(8'h40, "reg");
        i2c_start();
        send_byte(8'hA1, "dev+R");
        recv_byte(1'b1, "rd 0x40", got);
        chk("literal rd 0x40", 16'(got), 16'h005A);
        i2c_stop();

        repeat (10) @(posedge clk);
        chk("pending expected writes", 16'(exp_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
